// File: rtl/srio_pkg.sv
// srio_pkg: shared SRIO NWRITE constants, FSM states and HELLO header assembly
package srio_pkg;

    localparam logic [3:0] FTYPE_NWRITE   = 4'h5;
    localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
    localparam logic [3:0] TTYPE_NWRITE_R = 4'h5;

    localparam int HDR_TID_LSB   = 56;
    localparam int HDR_FTYPE_LSB = 52;
    localparam int HDR_TTYPE_LSB = 48;
    localparam int HDR_PRIO_LSB  = 45;
    localparam int HDR_CRF_BIT   = 44;
    localparam int HDR_SIZE_LSB  = 36;

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_e;

    function automatic logic [63:0] hello_hdr(
        input logic [7:0]  tid,
        input logic [3:0]  ttype,
        input logic [1:0]  prio,
        input logic        crf,
        input logic [7:0]  size,
        input logic [33:0] addr
    );
        logic [63:0] h;
        h = '0;
        h[HDR_TID_LSB +: 8]   = tid;
        h[HDR_FTYPE_LSB +: 4] = FTYPE_NWRITE;
        h[HDR_TTYPE_LSB +: 4] = ttype;
        h[HDR_PRIO_LSB +: 2]  = prio;
        h[HDR_CRF_BIT]        = crf;
        h[HDR_SIZE_LSB +: 8]  = size;
        h[33:0]               = addr;
        return h;
    endfunction

endpackage

// File: rtl/nwrite_seg_calc.sv
// nwrite_seg_calc: payload size, beat count and last-segment flag for the next packet
module nwrite_seg_calc #(
    parameter int MAX_SEG_BYTES = 256
) (
    input  logic [12:0] rem_bytes_i,
    output logic [8:0]  seg_bytes_o,
    output logic [5:0]  seg_beats_o,
    output logic        last_seg_o
);

    assign last_seg_o  = rem_bytes_i <= 13'(MAX_SEG_BYTES);
    // When this is the last segment the remainder fits in 9 bits, so the slice is lossless.
    assign seg_bytes_o = last_seg_o ? rem_bytes_i[8:0] : 9'(MAX_SEG_BYTES);
    assign seg_beats_o = 6'((seg_bytes_o + 9'd7) >> 3);

endmodule

// File: rtl/nwrite_req_pack.sv
// nwrite_req_pack: splits a user write into HELLO NWRITE/NWRITE_R packets on the ireq stream
module nwrite_req_pack
    import srio_pkg::*;
#(
    parameter int         MAX_SEG_BYTES = 256,
    parameter logic [1:0] PRIO          = 2'b01,
    parameter logic       CRF           = 1'b0,
    parameter int         WITH_RESP     = 0,
    parameter logic [7:0] TID_INIT      = 8'h00
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic [33:0] user_addr_in,
    input  logic [11:0] user_tsize_in,
    input  logic [63:0] user_tdata_in,
    input  logic        user_tvalid_in,
    input  logic [7:0]  user_tkeep_in,
    input  logic        user_tlast_in,
    output logic        user_tready_o,
    output logic        nwr_ready_o,
    output logic        nwr_busy_o,
    output logic        nwr_done_o,
    output logic        len_err_o,
    input  logic [15:0] src_id_in,
    input  logic [15:0] dest_id_in,
    output logic [63:0] ireq_tdata_o,
    output logic        ireq_tvalid_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic        ireq_tlast_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        ireq_tready_in
);

    localparam logic [3:0] TTYPE = (WITH_RESP != 0) ? TTYPE_NWRITE_R : TTYPE_NWRITE;

    state_e      state_q, state_d;
    logic [33:0] addr_q, addr_d;
    logic [12:0] rem_q, rem_d;
    logic [7:0]  tid_q, tid_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        len_err_q, len_err_d;
    logic [8:0]  seg_bytes;
    logic [5:0]  seg_beats;
    logic        last_seg;
    logic        final_beat;
    logic        early_last;

    nwrite_seg_calc #(.MAX_SEG_BYTES(MAX_SEG_BYTES)) u_seg_calc (
        .rem_bytes_i (rem_q),
        .seg_bytes_o (seg_bytes),
        .seg_beats_o (seg_beats),
        .last_seg_o  (last_seg)
    );

    assign nwr_ready_o = log_rst_n && state_q == ST_IDLE;
    assign nwr_busy_o  = state_q == ST_HDR || state_q == ST_DATA;
    assign nwr_done_o  = state_q == ST_DONE;
    assign len_err_o   = len_err_q;

    // State and transfer bookkeeping registers; reset drops any packet in flight.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            tid_q     <= TID_INIT;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            tid_q     <= tid_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    // Next-state logic plus header emission and combinational data pass-through.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        tid_d         = tid_q;
        cnt_d         = cnt_q;
        len_err_d     = 1'b0;
        user_tready_o = 1'b0;
        ireq_tdata_o  = '0;
        ireq_tvalid_o = 1'b0;
        ireq_tkeep_o  = '0;
        ireq_tlast_o  = 1'b0;
        ireq_tuser_o  = '0;
        final_beat    = last_seg && cnt_q == 6'd1;
        early_last    = user_tlast_in && !final_beat;
        case (state_q)
            ST_IDLE: begin
                if (user_tvalid_in) begin
                    addr_d  = user_addr_in;
                    rem_d   = 13'(user_tsize_in) + 13'd1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                ireq_tvalid_o = 1'b1;
                ireq_tkeep_o  = 8'hFF;
                ireq_tuser_o  = {src_id_in, dest_id_in};
                ireq_tdata_o  = hello_hdr(tid_q, TTYPE, PRIO, CRF, 8'(seg_bytes - 9'd1), addr_q);
                if (ireq_tready_in) begin
                    tid_d   = tid_q + 8'd1;
                    cnt_d   = seg_beats;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                ireq_tdata_o  = user_tdata_in;
                ireq_tvalid_o = user_tvalid_in;
                user_tready_o = ireq_tready_in;
                ireq_tuser_o  = {src_id_in, dest_id_in};
                ireq_tkeep_o  = final_beat ? user_tkeep_in : 8'hFF;
                ireq_tlast_o  = cnt_q == 6'd1 || early_last;
                if (user_tvalid_in && ireq_tready_in) begin
                    cnt_d = cnt_q - 6'd1;
                    if (early_last) begin
                        len_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (cnt_q == 6'd1) begin
                        rem_d     = rem_q - 13'(seg_bytes);
                        addr_d    = addr_q + 34'(seg_bytes);
                        state_d   = last_seg ? ST_DONE : ST_HDR;
                        len_err_d = last_seg && !user_tlast_in;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nwrite_req_pack.sv
// tb_nwrite_req_pack: directed vectors for nwrite_req_pack with hand-computed beats
module tb_nwrite_req_pack;

    localparam logic [15:0] SRC = 16'h0011;
    localparam logic [15:0] DST = 16'h00AA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] u_addr;
    logic [11:0] u_tsize;
    logic [63:0] u_tdata;
    logic        u_tvalid;
    logic [7:0]  u_tkeep;
    logic        u_tlast;
    logic        i_tready;
    logic        tog;

    logic        u_tready, ready, busy, done, lerr;
    logic [63:0] i_tdata;
    logic        i_tvalid, i_tlast;
    logic [7:0]  i_tkeep;
    logic [31:0] i_tuser;

    logic        r_utready, r_ready, r_busy, r_done, r_lerr;
    logic [63:0] r_tdata;
    logic        r_tvalid, r_tlast;
    logic [7:0]  r_tkeep;
    logic [31:0] r_tuser;

    int n_tests = 0;
    int n_fail  = 0;
    int done_n  = 0;
    int err_n   = 0;
    int d0, e0;

    logic [72:0] q0[$];
    logic [72:0] q1[$];
    logic [72:0] ex[$];

    always #5 clk = ~clk;

    nwrite_req_pack dut (
        .log_clk(clk), .log_rst_n(rst_n),
        .user_addr_in(u_addr), .user_tsize_in(u_tsize), .user_tdata_in(u_tdata),
        .user_tvalid_in(u_tvalid), .user_tkeep_in(u_tkeep), .user_tlast_in(u_tlast),
        .user_tready_o(u_tready), .nwr_ready_o(ready), .nwr_busy_o(busy),
        .nwr_done_o(done), .len_err_o(lerr), .src_id_in(SRC), .dest_id_in(DST),
        .ireq_tdata_o(i_tdata), .ireq_tvalid_o(i_tvalid), .ireq_tkeep_o(i_tkeep),
        .ireq_tlast_o(i_tlast), .ireq_tuser_o(i_tuser), .ireq_tready_in(i_tready)
    );

    nwrite_req_pack #(.WITH_RESP(1)) dut_r (
        .log_clk(clk), .log_rst_n(rst_n),
        .user_addr_in(u_addr), .user_tsize_in(u_tsize), .user_tdata_in(u_tdata),
        .user_tvalid_in(u_tvalid), .user_tkeep_in(u_tkeep), .user_tlast_in(u_tlast),
        .user_tready_o(r_utready), .nwr_ready_o(r_ready), .nwr_busy_o(r_busy),
        .nwr_done_o(r_done), .len_err_o(r_lerr), .src_id_in(SRC), .dest_id_in(DST),
        .ireq_tdata_o(r_tdata), .ireq_tvalid_o(r_tvalid), .ireq_tkeep_o(r_tkeep),
        .ireq_tlast_o(r_tlast), .ireq_tuser_o(r_tuser), .ireq_tready_in(i_tready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] hb(input logic [7:0] tid, input logic [3:0] tt,
                                       input logic [7:0] sz, input logic [33:0] a);
        return {1'b0, 8'hFF, tid, 4'h5, tt, 1'b0, 2'b01, 1'b0, sz, 2'b00, a};
    endfunction

    function automatic logic [72:0] db(input logic [7:0] xid, input int k,
                                       input logic [7:0] keep, input logic last);
        return {last, keep, 16'hDA7A, xid, 8'h00, 32'(k)};
    endfunction

    task automatic exp_seg(input logic [7:0] tid, input logic [3:0] tt, input logic [7:0] sz,
                           input logic [33:0] a, input logic [7:0] xid, input int k0,
                           input int nb, input logic [7:0] lkeep);
        ex.push_back(hb(tid, tt, sz, a));
        for (int k = k0; k < k0 + nb; k++)
            ex.push_back(db(xid, k, (k == k0 + nb - 1) ? lkeep : 8'hFF, k == k0 + nb - 1));
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_nbeats"}, 128'(q0.size()), 128'(ex.size()));
        for (int i = 0; i < ex.size() && i < q0.size(); i++)
            check($sformatf("%s_b%0d", tag, i), q0[i], ex[i]);
    endtask

    task automatic start();
        q0.delete();
        q1.delete();
        ex.delete();
        d0 = done_n;
        e0 = err_n;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!u_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("tready_wait", u_tready, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("idle_wait", ready, 1'b1);
    endtask

    task automatic send(input logic [33:0] a, input logic [11:0] ts, input int nb,
                        input int last_at, input logic [7:0] fkeep, input logic [7:0] xid);
        @(posedge clk);
        #1;
        u_addr  = a;
        u_tsize = ts;
        for (int k = 0; k < nb; k++) begin
            u_tdata  = {16'hDA7A, xid, 8'h00, 32'(k)};
            u_tkeep  = (k == nb - 1) ? fkeep : 8'hFF;
            u_tlast  = (k == last_at);
            u_tvalid = 1'b1;
            wait_ready();
            @(posedge clk);
            #1;
        end
        u_tvalid = 1'b0;
        u_tlast  = 1'b0;
    endtask

    initial begin
        i_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_tready = tog ? ~i_tready : 1'b1;
        end
    end

    initial begin
        logic        pv = 1'b0;
        logic        pr = 1'b1;
        logic [63:0] pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) check("hold", {i_tvalid, i_tdata}, {1'b1, pd});
                if (i_tvalid && i_tready) begin
                    q0.push_back({i_tlast, i_tkeep, i_tdata});
                    check("tuser", i_tuser, {SRC, DST});
                end
                if (r_tvalid && i_tready) q1.push_back({r_tlast, r_tkeep, r_tdata});
                done_n += int'(done);
                err_n  += int'(lerr);
            end
            pv = i_tvalid;
            pr = i_tready;
            pd = i_tdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] a;
        rst_n = 1'b0; tog = 1'b0;
        u_addr = '0; u_tsize = '0; u_tdata = '0; u_tvalid = 1'b0; u_tkeep = '0; u_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", i_tvalid, 1'b0);
        check("rst_tready", u_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lerr", lerr, 1'b0);
        check("rst_tlast_keep", {i_tlast, i_tkeep}, 9'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 1'b1);

        start();
        send(34'h1000, 12'd512, 65, 64, 8'h01, 8'd1);
        wait_idle();
        exp_seg(8'd0, 4'h4, 8'hFF, 34'h1000, 8'd1, 0, 32, 8'hFF);
        exp_seg(8'd1, 4'h4, 8'hFF, 34'h1100, 8'd1, 32, 32, 8'hFF);
        exp_seg(8'd2, 4'h4, 8'h00, 34'h1200, 8'd1, 64, 1, 8'h01);
        cmp_q("x513");
        check("x513_done", 128'(done_n - d0), 128'(1));
        check("x513_err", 128'(err_n - e0), 128'(0));

        start();
        send(34'h1000, 12'd246, 31, 30, 8'h7F, 8'd2);
        wait_idle();
        exp_seg(8'd3, 4'h4, 8'hF6, 34'h1000, 8'd2, 0, 31, 8'h7F);
        cmp_q("x247");
        check("x247_done", 128'(done_n - d0), 128'(1));

        start();
        tog = 1'b1;
        send(34'h3000, 12'd255, 32, 31, 8'hFF, 8'd3);
        wait_idle();
        tog = 1'b0;
        exp_seg(8'd4, 4'h4, 8'hFF, 34'h3000, 8'd3, 0, 32, 8'hFF);
        cmp_q("bp256");
        check("bp256_done", 128'(done_n - d0), 128'(1));

        start();
        send(34'h4000, 12'd255, 10, 9, 8'h0F, 8'd4);
        wait_idle();
        exp_seg(8'd5, 4'h4, 8'hFF, 34'h4000, 8'd4, 0, 10, 8'hFF);
        cmp_q("early");
        check("early_err", 128'(err_n - e0), 128'(1));
        check("early_done", 128'(done_n - d0), 128'(1));

        start();
        send(34'h6000, 12'd15, 2, -1, 8'hFF, 8'd5);
        wait_idle();
        exp_seg(8'd6, 4'h4, 8'h0F, 34'h6000, 8'd5, 0, 2, 8'hFF);
        cmp_q("nolast");
        check("nolast_err", 128'(err_n - e0), 128'(1));
        check("nolast_done", 128'(done_n - d0), 128'(1));

        start();
        send(34'h5000, 12'd255, 4, -1, 8'hFF, 8'd6);
        @(posedge clk);
        #1;
        u_tdata  = {16'hDA7A, 8'd6, 8'h00, 32'd4};
        u_tvalid = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_tvalid", i_tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", i_tvalid, 1'b0);
        check("mid_rst_tready", u_tready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        u_tvalid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", ready, 1'b1);

        for (int i = 0; i <= 256; i++) begin
            start();
            a = 34'h8000 + 34'(i * 8);
            send(a, 12'd7, 1, 0, 8'hFF, 8'(i));
            wait_idle();
            exp_seg(8'(i), 4'h4, 8'h07, a, 8'(i), 0, 1, 8'hFF);
            cmp_q("w8");
            check("w8_resp_hdr", (q1.size() > 0) ? q1[0] : 73'h0, hb(8'(i), 4'h5, 8'h07, a));
            check("w8_done", 128'(done_n - d0), 128'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nwrite_req_pack.md
Name: nwrite_req_pack

Overview:
- Sits directly downstream of the NWRITE user data generator and upstream of the SRIO Gen2 core's ireq AXI4-Stream port.
- Accepts one user write transfer: a 34-bit byte address, a 12-bit length-minus-one, and a 64-bit data stream.
- Splits the transfer into NWRITE or NWRITE_R packets of at most MAX_SEG_BYTES of payload each.
- Prepends a HELLO-format header beat to every packet and drives the nwr_ready/busy/done handshake back to the generator.

Parameters:
- MAX_SEG_BYTES, 256, maximum payload per packet; power of two, 8..256.
- PRIO, 2'b01, HELLO priority field.
- CRF, 1'b0, HELLO CRF bit.
- WITH_RESP, 0, 0 selects NWRITE (TTYPE 4); 1 selects NWRITE_R (TTYPE 5).
- TID_INIT, 8'h00, first transaction ID after reset.

Ports:
- log_clk  in  1  logic clock.
- log_rst_n  in  1  asynchronous active-low reset.
- user_addr_in  in  34  transfer start byte address; must be 8-byte aligned.
- user_tsize_in  in  12  transfer length in bytes minus 1 (range 0..4095).
- user_tdata_in  in  64  payload beat.
- user_tvalid_in  in  1  payload valid.
- user_tkeep_in  in  8  byte enables; meaningful on the final beat only.
- user_tlast_in  in  1  final payload beat.
- user_tready_o  out  1  payload accepted.
- nwr_ready_o  out  1  idle, able to take a new transfer.
- nwr_busy_o  out  1  transfer in progress.
- nwr_done_o  out  1  one-cycle pulse when a transfer completes.
- len_err_o  out  1  one-cycle pulse when upstream tlast disagrees with the length.
- src_id_in  in  16  source device ID.
- dest_id_in  in  16  destination device ID.
- ireq_tdata_o  out  64  header or payload beat to the core.
- ireq_tvalid_o  out  1  ireq beat valid.
- ireq_tkeep_o  out  8  ireq byte enables.
- ireq_tlast_o  out  1  last beat of the current packet.
- ireq_tuser_o  out  32  {src_id, dest_id}, driven on every beat.
- ireq_tready_in  in  1  core accepts the ireq beat.

Behaviour:
- Reset (async, log_rst_n low):
  - State IDLE; all ireq outputs and user_tready_o 0.
  - nwr_busy_o, nwr_done_o and len_err_o 0; nwr_ready_o 1 once reset is released.
  - TID set to TID_INIT.
  - Reset mid-packet abandons the packet immediately, with no cleanup beat.
- States IDLE, HDR, DATA, DONE.
- IDLE:
  - nwr_ready_o=1, user_tready_o=0.
  - On user_tvalid_in=1: latch addr and tsize, set rem_bytes = tsize+1 (13-bit), go to HDR. The data beat is not consumed.
- HDR:
  - ireq_tvalid_o=1, ireq_tkeep_o=8'hFF, ireq_tlast_o=0.
  - seg_bytes = min(rem_bytes, MAX_SEG_BYTES).
  - Header bit fields:
    - [63:56] TID
    - [55:52] 4'h5
    - [51:48] TTYPE
    - [47] 0
    - [46:45] PRIO
    - [44] CRF
    - [43:36] seg_bytes-1
    - [35:34] 0
    - [33:0] current segment address
  - On ireq_tready_in: TID increments (wraps 255 to 0), beat counter loads ceil(seg_bytes/8), go to DATA.
- DATA (combinational pass-through, no added latency):
  - ireq_tdata_o = user_tdata_in, ireq_tvalid_o = user_tvalid_in, user_tready_o = ireq_tready_in.
  - ireq_tkeep_o = 8'hFF except on the final beat of the final segment, where it equals user_tkeep_in.
  - ireq_tlast_o = 1 when the beat counter equals 1.
  - A beat transfers when user_tvalid_in and ireq_tready_in are both 1; the counter then decrements.
  - On the last beat of a segment: rem_bytes -= seg_bytes and addr += seg_bytes. If rem_bytes becomes 0, go to DONE; otherwise go to HDR.
- Length error:
  - Case 1: user_tlast_in=1 on a beat that is not the transfer's final beat. Pulse len_err_o, force ireq_tlast_o=1 on that beat, go to DONE.
  - Case 2: user_tlast_in=0 on the computed final beat. Pulse len_err_o; the packet still ends by count.
- DONE: nwr_done_o=1 for one cycle, then go to IDLE.
- nwr_busy_o = 1 in HDR and DATA.
- Backpressure: ireq_tvalid_o and ireq_tdata_o stay stable while ireq_tready_in=0 in HDR. DATA inherits stability from the upstream AXI rules.
- Zero-length transfers are not possible (tsize 0 means 1 byte).

Decomposition:
- Shared package srio_pkg:
  - FTYPE_NWRITE = 4'h5
  - TTYPE_NWRITE = 4'h4
  - TTYPE_NWRITE_R = 4'h5
  - state encoding
  - HELLO field offsets
  - a header-assembly function taking {tid, ttype, prio, crf, size, addr}
- One natural sub-module: nwrite_seg_calc. Combinational min/ceil computation of seg_bytes, beat count and last-segment flag from rem_bytes.

Test Plan:
- addr 0x0_0000_1000, tsize 246: one header with size 0xF6 and addr 0x1000, then 31 data beats. Beat 31 has tlast=1 and tkeep = upstream tkeep. nwr_done_o pulses once.
- addr 0x1000, tsize 512 (513 B): three packets.
  - Headers: size 0xFF addr 0x1000, size 0xFF addr 0x1100, size 0x00 addr 0x1200.
  - Data beats per packet: 32, 32, 1.
  - TIDs 0, 1, 2.
- tsize 255, ireq_tready_in toggling every cycle: header held stable until accepted; 32 data beats delivered in order with no loss or duplication.
- tsize 255 with upstream tlast on beat 10: len_err_o pulses; ireq_tlast_o=1 on beat 10; state returns to IDLE after the done pulse.
- Reset asserted on data beat 5 of a 32-beat packet: ireq_tvalid_o=0 immediately; after release nwr_ready_o=1 and TID = TID_INIT.
- WITH_RESP=1, 256 consecutive 8-byte transfers: header [51:48]=4'h5; TID wraps from 0xFF to 0x00.
